// File: rtl/clk_tick_monitor.sv
// Derived-clock period checker: measures TICK_IN rising-edge spacing in CLK100MHz cycles,
// qualifies it against EXP_PERIOD +/- TOL and reports LOCKED / FAULT status.
module clk_tick_monitor #(
    parameter int unsigned EXP_PERIOD = 2048,
    parameter int unsigned TOL        = 16,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 20
) (
    input  logic             CLK100MHz,
    input  logic             RESETn,
    input  logic             TICK_IN,
    input  logic             CLEAR,
    output logic             LOCKED,
    output logic             FAULT,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
    output logic [7:0]       ERR_COUNT
);

    localparam int unsigned GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

    localparam logic [CNT_W-1:0]  WIN_LO    = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0]  WIN_HI    = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0]  TMO_VAL   = CNT_W'(EXP_PERIOD + TOL + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_ACQUIRE,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t             state_q;
    logic [GOOD_W-1:0]  good_q;
    logic               locked_q;
    logic               fault_q;
    logic [7:0]         err_q;
    logic [CNT_W-1:0]   period_q;
    logic               pvalid_q;

    logic               sync1_q;
    logic               sync2_q;
    logic               prev_q;
    logic               rise_q;
    logic               rise_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               in_win;
    logic               timeout;
    logic               go_fault;

    // Two-flop synchronizer, then a registered one-cycle rising-edge pulse.
    assign rise_d = sync2_q & ~prev_q;

    always_ff @(posedge CLK100MHz or negedge RESETn) begin
        if (!RESETn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= TICK_IN;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= rise_d;
        end
    end

    // cnt holds the cycles elapsed since the previous edge during the edge cycle itself.
    always_comb begin
        cnt_d = cnt_q;
        if (CLEAR) begin
            cnt_d = '0;
        end else if (rise_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHz or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign in_win  = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    assign timeout = ~rise_q && (cnt_q == TMO_VAL);

    // CLEAR has priority over any fault cause arriving in the same cycle.
    assign go_fault = ~CLEAR &&
                      (((state_q != S_FAULT) && timeout) ||
                       ((state_q == S_LOCKED) && rise_q && ~in_win));

    always_ff @(posedge CLK100MHz or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= S_SEARCH;
            good_q   <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            err_q    <= '0;
            period_q <= '0;
            pvalid_q <= 1'b0;
        end else begin
            pvalid_q <= 1'b0;
            if (CLEAR) begin
                state_q  <= S_SEARCH;
                good_q   <= '0;
                locked_q <= 1'b0;
                fault_q  <= 1'b0;
            end else begin
                if (rise_q && (state_q != S_SEARCH)) begin
                    period_q <= cnt_q;
                    pvalid_q <= 1'b1;
                end
                if (go_fault) begin
                    state_q  <= S_FAULT;
                    locked_q <= 1'b0;
                    fault_q  <= 1'b1;
                    if (err_q != '1) begin
                        err_q <= err_q + 1'b1;
                    end
                end else begin
                    case (state_q)
                        S_SEARCH: begin
                            if (rise_q) begin
                                state_q <= S_ACQUIRE;
                                good_q  <= '0;
                            end
                        end
                        S_ACQUIRE: begin
                            if (rise_q) begin
                                if (!in_win) begin
                                    good_q <= '0;
                                end else if (good_q == GOOD_LAST) begin
                                    state_q  <= S_LOCKED;
                                    locked_q <= 1'b1;
                                end else begin
                                    good_q <= good_q + 1'b1;
                                end
                            end
                        end
                        S_LOCKED: begin
                            locked_q <= 1'b1;
                        end
                        default: begin
                            fault_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign LOCKED       = locked_q;
    assign FAULT        = fault_q;
    assign PERIOD       = period_q;
    assign PERIOD_VALID = pvalid_q;
    assign ERR_COUNT    = err_q;

endmodule

// File: tb/tb_clk_tick_monitor.sv
// Directed bench for clk_tick_monitor: period expectations go through a scoreboard queue,
// status outputs are checked at hand-computed points of each scenario.
module tb_clk_tick_monitor;

    localparam int unsigned EXP   = 512;
    localparam int unsigned TOL   = 16;
    localparam int unsigned LOCKN = 4;
    localparam int unsigned W     = 12;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         tick   = 1'b0;
    logic         clr    = 1'b0;
    logic         locked;
    logic         fault;
    logic [W-1:0] period;
    logic         pvalid;
    logic [7:0]   errc;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int exp_q[$];
    bit armed     = 1'b0;
    int last_edge = 0;
    int err_exp   = 0;

    clk_tick_monitor #(
        .EXP_PERIOD(EXP),
        .TOL       (TOL),
        .LOCK_COUNT(LOCKN),
        .CNT_W     (W)
    ) dut (
        .CLK100MHz   (clk),
        .RESETn      (rst_n),
        .TICK_IN     (tick),
        .CLEAR       (clr),
        .LOCKED      (locked),
        .FAULT       (fault),
        .PERIOD      (period),
        .PERIOD_VALID(pvalid),
        .ERR_COUNT   (errc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every PERIOD_VALID pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && pvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_period_valid actual=%0d expected=none", period);
            end else begin
                chk("period", int'(period), exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int p);
        tick = 1'b1;
        if (armed) exp_q.push_back(cyc - last_edge);
        armed     = 1'b1;
        last_edge = cyc;
        repeat (p / 2) step();
        tick = 1'b0;
        repeat (p - p / 2) step();
    endtask

    // Edge whose synchronized pulse lands in the same cycle as CLEAR.
    task automatic wave_clr(input int p);
        tick = 1'b1;
        repeat (3) step();
        clr = 1'b1;
        step();
        clr   = 1'b0;
        armed = 1'b0;
        repeat (p / 2 - 4) step();
        tick = 1'b0;
        repeat (p - p / 2) step();
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        step();
        clr   = 1'b0;
        armed = 1'b0;
    endtask

    task automatic lock_seq(input string tag);
        for (int i = 1; i <= 5; i++) begin
            wave(EXP);
            if (i == 4) chk({tag, "_locked_after4"}, int'(locked), 0);
        end
        chk({tag, "_locked_after5"}, int'(locked), 1);
        chk({tag, "_fault"}, int'(fault), 0);
    endtask

    initial begin
        int t;
        repeat (3) step();
        chk("rst_locked", int'(locked), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_pvalid", int'(pvalid), 0);
        chk("rst_err", int'(errc), 0);
        rst_n = 1'b1;
        step();

        // Nominal lock, one extra period while locked
        lock_seq("s1");
        wave(EXP);
        chk("s1_locked_hold", int'(locked), 1);

        // Stuck-low input: timeout at EXP+TOL+1 cycles after the last synchronized edge
        t = last_edge;
        while (cyc < t + int'(EXP + TOL + 4)) step();
        chk("s3_fault_before_tmo", int'(fault), 0);
        chk("s3_locked_before_tmo", int'(locked), 1);
        step();
        chk("s3_fault_at_tmo", int'(fault), 1);
        chk("s3_locked_at_tmo", int'(locked), 0);
        err_exp++;
        chk("s3_err", int'(errc), err_exp);
        repeat (50) step();

        // CLEAR out of FAULT and reacquire
        pulse_clear();
        chk("s4_fault_cleared", int'(fault), 0);
        lock_seq("s4");
        chk("s4_err_kept", int'(errc), err_exp);

        // CLEAR coincident with an edge: that edge is discarded
        wave_clr(EXP);
        chk("s4b_locked_after_clr", int'(locked), 0);
        lock_seq("s4b");

        // Window boundaries
        wave(EXP - TOL);
        wave(EXP + TOL);
        wave(EXP);
        chk("s5_locked_in_bounds", int'(locked), 1);
        chk("s5_fault_in_bounds", int'(fault), 0);
        wave(EXP - TOL - 1);
        wave(EXP);
        chk("s5_fault_short", int'(fault), 1);
        chk("s5_locked_short", int'(locked), 0);
        err_exp++;
        chk("s5_err_short", int'(errc), err_exp);
        pulse_clear();
        lock_seq("s5b");
        wave(EXP + TOL + 1);
        chk("s5_locked_before_long_edge", int'(locked), 1);
        wave(EXP);
        chk("s5_fault_long", int'(fault), 1);
        err_exp++;
        chk("s5_err_long", int'(errc), err_exp);

        // Asynchronous reset while locked
        pulse_clear();
        lock_seq("s6pre");
        #1 rst_n = 1'b0;
        #1;
        chk("s6_async_locked", int'(locked), 0);
        chk("s6_async_fault", int'(fault), 0);
        chk("s6_async_period", int'(period), 0);
        chk("s6_async_err", int'(errc), 0);
        err_exp = 0;
        armed   = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        lock_seq("s6");

        // Out-of-window but fast periods never lock nor time out
        pulse_clear();
        for (int i = 0; i < 8; i++) wave(EXP - 32);
        chk("s2_locked", int'(locked), 0);
        chk("s2_fault", int'(fault), 0);
        // Too-slow period times out in ACQUIRE; edges still captured in FAULT
        wave(EXP + 28);
        chk("s2_fault_slow", int'(fault), 1);
        err_exp++;
        chk("s2_err", int'(errc), err_exp);
        wave(EXP);
        chk("s2_fault_sticky", int'(fault), 1);

        repeat (10) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
